ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard using the PS/2 request-to-send sequence, odd parity and device ACK check. Sits beside the keyboard receiver inside PrincipalTeclado and shares the open-drain ps2c/ps2d pads with it. `tx_idle` gates the receiver's `rx_en` so the receiver ignores frames while the host is driving the bus.

---
 rtl/ps2_host_tx_pkg.sv | 24 ++
 rtl/ps2_host_tx_clk_filter.sv | 51 +++++
 rtl/ps2_host_tx.sv | 132 +++++++++++++
 tb/tb_ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: definitions shared by the PS/2 host transmitter and the
// keyboard receiver -- FSM state type, well-known command bytes, the device
// ACK byte and a helper that builds the transmitted data+parity word.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // {odd parity, data}; shifted out LSB first.
    function automatic logic [8:0] frame_word(input logic [7:0] b);
        return {~^b, b};
    endfunction

endpackage

// File: rtl/ps2_host_tx_clk_filter.sv
// ps2_host_tx_clk_filter: two-flop synchronisers for the PS/2 clock and data
// pads, a FILTER_LEN-deep glitch filter on the clock and a one-cycle strobe on
// each filtered 1->0 clock transition.
//   clk, reset   system clock, synchronous active-high reset
//   ps2c_in      asynchronous pad-level PS/2 clock
//   ps2d_in      asynchronous pad-level PS/2 data
//   ps2d_sync    synchronised PS/2 data
//   fall         one-cycle pulse on a filtered falling edge of the PS/2 clock
module ps2_host_tx_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    input  logic ps2d_in,
    output logic ps2d_sync,
    output logic fall
);

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] hist;
    logic                  filt;

    // The idle bus is high, so everything resets to 1 to avoid a spurious fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync <= '1;
            d_sync <= '1;
            hist   <= '1;
            filt   <= 1'b1;
            fall   <= 1'b0;
        end else begin
            c_sync <= {c_sync[0], ps2c_in};
            d_sync <= {d_sync[0], ps2d_in};
            hist   <= {hist[FILTER_LEN-2:0], c_sync[1]};
            fall   <= 1'b0;
            if (hist == '1) begin
                filt <= 1'b1;
            end else if (hist == '0) begin
                if (filt) begin
                    fall <= 1'b1;
                end
                filt <= 1'b0;
            end
        end
    end

    assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte using
// request-to-send (clock inhibit), start bit, 8 data bits LSB first, odd
// parity, stop bit, and checks the device ACK. The open-drain pads are driven
// by the *_oe outputs in the enclosing wrapper (pad = oe ? 0 : z).
//   clk, reset        system clock, synchronous active-high reset
//   wr_ps2, din       one-cycle send request and command byte (IDLE only)
//   ps2c_in, ps2d_in  pad-level PS/2 clock and data
//   ps2c_oe, ps2d_oe  1 = pull the line low
//   tx_idle           high while idle; gates the receiver
//   tx_done_tick      one-cycle pulse on device ACK
//   tx_err            one-cycle pulse on timeout or missing ACK
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    tx_state_t      state;
    logic [8:0]     sreg;
    logic [3:0]     nbit;
    logic [CW-1:0]  cnt;
    logic           fall;
    logic           d_sync;

    ps2_host_tx_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2c_in  (ps2c_in),
        .ps2d_in  (ps2d_in),
        .ps2d_sync(d_sync),
        .fall     (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            sreg         <= '0;
            nbit         <= '0;
            cnt          <= '0;
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            tx_idle      <= 1'b1;
            tx_done_tick <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            tx_err       <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    // tx_idle rises one cycle after entering IDLE, i.e. after the pulse.
                    tx_idle <= ~wr_ps2;
                    if (wr_ps2) begin
                        sreg    <= frame_word(din);
                        cnt     <= '0;
                        nbit    <= '0;
                        ps2c_oe <= 1'b1;
                        state   <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                        cnt     <= '0;
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // START/DATA/STOP share the per-edge timeout.
                    if (fall) begin
                        cnt <= '0;
                        case (state)
                            ST_START: begin
                                ps2d_oe <= ~sreg[0];
                                state   <= ST_DATA;
                            end
                            ST_DATA: begin
                                if (nbit == 4'd8) begin
                                    ps2d_oe <= 1'b0;
                                    state   <= ST_STOP;
                                end else begin
                                    sreg    <= {1'b0, sreg[8:1]};
                                    ps2d_oe <= ~sreg[1];
                                    nbit    <= nbit + 1'b1;
                                end
                            end
                            default: begin
                                // Stop bit is on the line; the 11th fall carries the ACK.
                                tx_done_tick <= ~d_sync;
                                tx_err       <= d_sync;
                                state        <= ST_IDLE;
                            end
                        endcase
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        cnt     <= '0;
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        tx_err  <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 keyboard that
// answers the request-to-send, clocks the frame, captures the bits on clock
// rising edges and optionally ACKs. Expected frames come from the byte itself.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int unsigned INH = 100;
    localparam int unsigned TMO = 20000;
    localparam realtime DEV_HALF = 1500ns;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = '0;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_in, ps2d_in;

    assign ps2c_in = !(ps2c_oe || dev_c_low);
    assign ps2d_in = !(ps2d_oe || dev_d_low);

    int unsigned total = 0, bad = 0;
    int unsigned cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int unsigned rts_run = 0, rts_len = 0, last_fall_cyc = 0;
    logic        d_at_drop = 1'b0, prev_c = 1'b0;

    always #5ns clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c_in     (ps2c_in),
        .ps2d_in     (ps2d_in),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and RTS length monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) done_cnt++;
        if (tx_err === 1'b1) err_cnt++;
        if (tx_done_tick === 1'b1 && tx_err === 1'b1) both_cnt++;
        if (ps2c_oe === 1'b1 && !prev_c) rts_run = 1;
        else if (ps2c_oe === 1'b1) rts_run++;
        else if (prev_c) begin
            rts_len   = rts_run;
            d_at_drop = ps2d_oe;
        end
        prev_c = (ps2c_oe === 1'b1);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic host_send(input logic [7:0] b);
        @(negedge clk);
        din = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("accept_idle_low", tx_idle, 0);
        check("accept_c_oe_high", ps2c_oe, 1);
    endtask

    // Keyboard model: waits for the start condition, then produces n_edges
    // clock falls, sampling data on each rising edge.
    task automatic dev_frame(input int n_edges, input bit ack, input bit glitch,
                             output logic [10:0] cap, output bit ok);
        int unsigned t;
        cap = '0;
        ok  = 1'b1;
        t   = 0;
        while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 2000) begin
            ok = 1'b0;
            return;
        end
        #DEV_HALF;
        cap[0] = ps2d_in;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11) begin
                if (ack) dev_d_low = 1'b1;
                #(DEV_HALF / 2);
            end
            dev_c_low = 1'b1;
            last_fall_cyc = cyc;
            #DEV_HALF;
            dev_c_low = 1'b0;
            if (k <= 10) cap[k] = ps2d_in;
            if (k == 11) dev_d_low = 1'b0;
            if (glitch && k == 5) begin
                #(DEV_HALF / 2);
                dev_c_low = 1'b1;
                #30ns;
                dev_c_low = 1'b0;
                #(DEV_HALF / 2);
            end else begin
                #DEV_HALF;
            end
        end
    endtask

    task automatic frame_test(input string tag, input logic [7:0] b, input bit ack, input bit glitch);
        int unsigned d0, e0;
        logic [10:0] cap;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        host_send(b);
        dev_frame(11, ack, glitch, cap, ok);
        repeat (5) @(negedge clk);
        check({tag, "_start_seen"}, ok, 1);
        check({tag, "_bits"}, cap, exp_frame(b));
        check({tag, "_done"}, done_cnt - d0, ack ? 1 : 0);
        check({tag, "_err"}, err_cnt - e0, ack ? 0 : 1);
        check({tag, "_idle"}, tx_idle, 1);
        check({tag, "_released"}, {ps2c_oe, ps2d_oe}, 0);
    endtask

    initial begin
        int unsigned d0, e0, t, delta;
        logic [10:0] cap, ef;
        bit ok;

        repeat (3) @(negedge clk);
        check("rst_c_oe", ps2c_oe, 0);
        check("rst_d_oe", ps2d_oe, 0);
        check("rst_idle", tx_idle, 1);
        check("rst_pulses", {tx_done_tick, tx_err}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        frame_test("set_led", PS2_CMD_SET_LED, 1'b1, 1'b0);
        check("rts_len", rts_len, INH);
        check("rts_d_at_drop", d_at_drop, 1);
        frame_test("zero", 8'h00, 1'b1, 1'b0);
        frame_test("reset_cmd", PS2_CMD_RESET, 1'b1, 1'b0);
        frame_test("no_ack", 8'h3C, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            frame_test("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Device stops clocking after fall #4.
        d0 = done_cnt;
        e0 = err_cnt;
        host_send(8'h5A);
        dev_frame(4, 1'b0, 1'b0, cap, ok);
        check("to_start_seen", ok, 1);
        ef = exp_frame(8'h5A);
        check("to_partial_bits", cap[4:0], ef[4:0]);
        t = 0;
        while (err_cnt == e0 && t < 25000) begin
            @(negedge clk);
            t++;
        end
        delta = cyc - last_fall_cyc;
        check("to_err", err_cnt - e0, 1);
        check("to_window", (delta >= TMO + 5 && delta <= TMO + 20), 1);
        check("to_no_done", done_cnt - d0, 0);
        check("to_released", {ps2c_oe, ps2d_oe}, 0);
        repeat (5) @(negedge clk);
        check("to_idle", tx_idle, 1);

        // Reset while d3 (= 0, line pulled low) is on the bus.
        d0 = done_cnt;
        e0 = err_cnt;
        host_send(8'hA5);
        dev_frame(4, 1'b0, 1'b0, cap, ok);
        check("mid_d_oe_before", ps2d_oe, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1ns;
        check("mid_rst_oe", {ps2c_oe, ps2d_oe}, 0);
        check("mid_rst_idle", tx_idle, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        // Request while busy is dropped; the original byte goes out.
        d0 = done_cnt;
        host_send(PS2_CMD_ECHO);
        repeat (20) @(negedge clk);
        din = 8'h12;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("busy_still_busy", tx_idle, 0);
        dev_frame(11, 1'b1, 1'b0, cap, ok);
        repeat (5) @(negedge clk);
        check("busy_start_seen", ok, 1);
        check("busy_echo_bits", cap, exp_frame(PS2_CMD_ECHO));
        check("busy_echo_done", done_cnt - d0, 1);
        check("busy_rts_len", rts_len, INH);

        frame_test("glitch", 8'hC3, 1'b1, 1'b1);

        check("never_both_pulses", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
